// File: rtl/ones_frame_accum.sv
// Frame accumulator for per-word ones counts: sums FRAME_LEN counts, tracks max/min,
// and holds the frame result on a valid/ready output until downstream takes it.
module ones_frame_accum #(
    parameter int CNT_W     = 4,
    parameter int FRAME_LEN = 16,
    parameter int SUM_W     = 8,
    parameter int THRESH    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [SUM_W-1:0] sum_out,
    output logic [CNT_W-1:0] max_out,
    output logic [CNT_W-1:0] min_out,
    output logic             over_thresh,
    output logic             range_err,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshake: input transfer = in_valid & in_ready on a rising edge; output
    // transfer = out_valid & out_ready. out_valid and the result bus hold until taken.

    localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [WC_W-1:0]  LAST_IDX  = WC_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] MAX_LEGAL = CNT_W'(8);
    localparam logic [CNT_W-1:0] MIN_INIT  = '1;
    localparam logic [SUM_W-1:0] THRESH_V  = SUM_W'(THRESH);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WC_W-1:0]  r_word_cnt;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_min;

    logic             w_in_xfer;
    logic             w_last;
    logic [SUM_W-1:0] w_sum_nxt;
    logic [CNT_W-1:0] w_max_nxt;
    logic [CNT_W-1:0] w_min_nxt;

    assign in_ready  = (r_state == ACCUM);
    assign w_in_xfer = in_valid & in_ready;
    assign w_last    = (r_word_cnt == LAST_IDX);
    assign w_sum_nxt = r_sum + SUM_W'(count);
    assign w_max_nxt = (count > r_max) ? count : r_max;
    assign w_min_nxt = (count < r_min) ? count : r_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_word_cnt  <= '0;
            r_sum       <= '0;
            r_max       <= '0;
            r_min       <= MIN_INIT;
            sum_out     <= '0;
            max_out     <= '0;
            min_out     <= '0;
            over_thresh <= 1'b0;
            range_err   <= 1'b0;
            out_valid   <= 1'b0;
        end else if (clear) begin
            // Abort the partial frame; the last published results stay on the bus.
            r_state    <= ACCUM;
            r_word_cnt <= '0;
            r_sum      <= '0;
            r_max      <= '0;
            r_min      <= MIN_INIT;
            range_err  <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_in_xfer) begin
                        if (count > MAX_LEGAL) begin
                            range_err <= 1'b1;
                        end
                        if (w_last) begin
                            sum_out     <= w_sum_nxt;
                            max_out     <= w_max_nxt;
                            min_out     <= w_min_nxt;
                            over_thresh <= (w_sum_nxt >= THRESH_V);
                            out_valid   <= 1'b1;
                            r_state     <= HOLD;
                            r_word_cnt  <= '0;
                            r_sum       <= '0;
                            r_max       <= '0;
                            r_min       <= MIN_INIT;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                            r_sum      <= w_sum_nxt;
                            r_max      <= w_max_nxt;
                            r_min      <= w_min_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_ones_frame_accum.sv
// Directed bench for ones_frame_accum: one task per scenario, inline checks,
// single summary line at the end.
module tb_ones_frame_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] count;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic [7:0] sum_out;
    logic [3:0] max_out;
    logic [3:0] min_out;
    logic       over_thresh;
    logic       range_err;
    logic       out_valid;
    logic       out_ready;

    int errors = 0;
    int checks = 0;

    ones_frame_accum #(
        .CNT_W(4), .FRAME_LEN(16), .SUM_W(8), .THRESH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .count(count), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .sum_out(sum_out),
        .max_out(max_out), .min_out(min_out), .over_thresh(over_thresh),
        .range_err(range_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Drives one word; caller is positioned 1ns after a rising edge.
    task automatic push(input logic [3:0] c);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        in_valid = 1'b1;
        count    = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; count = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({sum_out, max_out, min_out, over_thresh, range_err, out_valid} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: sum=%0d max=%0d min=%0d ot=%0b re=%0b ov=%0b required all 0",
                     sum_out, max_out, min_out, over_thresh, range_err, out_valid);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int rdy_bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (in_ready !== 1'b1) rdy_bad++;
            push(4'd4);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL b2b_in_ready: low on %0d words required 0", rdy_bad);
        end
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 8'd64 || max_out !== 4'd4 || min_out !== 4'd4 ||
            over_thresh !== 1'b1 || range_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: ov=%0b sum=%0d max=%0d min=%0d ot=%0b re=%0b required 1 64 4 4 1 0",
                     out_valid, sum_out, max_out, min_out, over_thresh, range_err);
        end
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_out !== 8'd64) begin
            errors++;
            $display("FAIL b2b_drain: ov=%0b ir=%0b sum=%0d required 0 1 64", out_valid, in_ready, sum_out);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] c;
        for (int i = 0; i < 16; i++) begin
            c = (i < 9) ? 4'(i) : 4'(i - 9);
            if (i == 15) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gaps_early_valid: got %0b before last word required 0", out_valid);
                end
            end
            push(c);
            if (i != 15) idle();
        end
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 8'd57 || max_out !== 4'd8 || min_out !== 4'd0 ||
            over_thresh !== 1'b0) begin
            errors++;
            $display("FAIL gaps_result: ov=%0b sum=%0d max=%0d min=%0d ot=%0b required 1 57 8 0 0",
                     out_valid, sum_out, max_out, min_out, over_thresh);
        end
        drain();
    endtask

    task automatic test_hold();
        int hold_bad = 0;
        for (int i = 0; i < 16; i++) push(4'd5);
        in_valid = 1'b1;
        count    = 4'd7;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_out !== 8'd80 ||
                max_out !== 4'd5 || min_out !== 4'd5 || over_thresh !== 1'b1) hold_bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles required 0 (ov=%0b ir=%0b sum=%0d)",
                     hold_bad, out_valid, in_ready, sum_out);
        end
        drain();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: ov=%0b ir=%0b required 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 16; i++) push(4'd2);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 8'd32 || max_out !== 4'd2 || min_out !== 4'd2 ||
            over_thresh !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_frame: ov=%0b sum=%0d max=%0d min=%0d ot=%0b required 1 32 2 2 0",
                     out_valid, sum_out, max_out, min_out, over_thresh);
        end
        drain();
    endtask

    task automatic test_range();
        for (int i = 0; i < 16; i++) push((i == 5) ? 4'd9 : 4'd1);
        checks++;
        if (range_err !== 1'b1 || sum_out !== 8'd24 || max_out !== 4'd9 || min_out !== 4'd1) begin
            errors++;
            $display("FAIL range_frame: re=%0b sum=%0d max=%0d min=%0d required 1 24 9 1",
                     range_err, sum_out, max_out, min_out);
        end
        drain();
        for (int i = 0; i < 16; i++) push(4'd1);
        checks++;
        if (range_err !== 1'b1 || sum_out !== 8'd16 || max_out !== 4'd1) begin
            errors++;
            $display("FAIL range_sticky: re=%0b sum=%0d max=%0d required 1 16 1", range_err, sum_out, max_out);
        end
        drain();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (range_err !== 1'b0) begin
            errors++;
            $display("FAIL range_clear: re=%0b required 0", range_err);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) push(4'd8);
        clear    = 1'b1;
        in_valid = 1'b1;
        count    = 4'd8;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum_out !== 8'd16 || max_out !== 4'd1) begin
            errors++;
            $display("FAIL clear_keep_outputs: ov=%0b sum=%0d max=%0d required 0 16 1", out_valid, sum_out, max_out);
        end
        for (int i = 0; i < 15; i++) push(4'd1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_early_valid: got %0b after 15 words required 0", out_valid);
        end
        push(4'd1);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 8'd16 || max_out !== 4'd1 || min_out !== 4'd1) begin
            errors++;
            $display("FAIL clear_frame: ov=%0b sum=%0d max=%0d min=%0d required 1 16 1 1",
                     out_valid, sum_out, max_out, min_out);
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) push(4'd5);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({sum_out, max_out, min_out, over_thresh, range_err, out_valid} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset: sum=%0d max=%0d min=%0d ot=%0b re=%0b ov=%0b required all 0",
                     sum_out, max_out, min_out, over_thresh, range_err, out_valid);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) push(4'd3);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_partial_lost: ov=%0b after 15 words required 0", out_valid);
        end
        push(4'd3);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 8'd48 || max_out !== 4'd3 || min_out !== 4'd3 ||
            over_thresh !== 1'b0) begin
            errors++;
            $display("FAIL reset_next_frame: ov=%0b sum=%0d max=%0d min=%0d ot=%0b required 1 48 3 3 0",
                     out_valid, sum_out, max_out, min_out, over_thresh);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_hold();
        test_range();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
